// File: rtl/oau_serial_mac_if.sv
// Stream interface for the serial odd-part multiply-accumulate unit.
//
// Input stream : in_valid / in_ready / in_data, plus size_sel (sampled on the
//                first beat of a vector) and clear (synchronous abort).
// Output stream: out_valid / out_ready / out_data[MAX_DIM/2] / out_size.
//
// master: the side that produces input beats and consumes result vectors.
// slave : the MAC itself.
interface oau_serial_mac_if #(
  parameter int IN_WIDTH = 16,
  parameter int MAX_DIM  = 8
);
  logic                       clear;
  logic                       size_sel;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_WIDTH-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [2*IN_WIDTH:0] out_data [MAX_DIM/2];
  logic                       out_size;

  modport master (
    output clear, size_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_size
  );

  modport slave (
    input  clear, size_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_size
  );
endinterface

// File: rtl/oau_serial_mac.sv
// Serial multiply-accumulate unit for the odd part of the IntDCT.
// One butterfly difference arrives per accepted beat. Every odd output k is
// accumulated in parallel against coefficient C[k][n]. After the last beat the
// (optionally rounded and shifted) vector moves into a separate output register,
// so collection of the next vector can overlap with the consumer.
//
// Ports:
//   HCLK      clock, rising edge
//   HRESETn   asynchronous active-low reset
//   bus       oau_serial_mac_if.slave
//             clear                        synchronous abort
//             size_sel                     0 = 4-point, 1 = 8-point
//             in_valid/in_ready/in_data    input beat stream
//             out_valid/out_ready/out_data/out_size  result vector
module oau_serial_mac #(
  parameter int IN_WIDTH = 16,
  parameter int MAX_DIM  = 8,
  parameter int SHIFT    = 0
) (
  input logic            HCLK,
  input logic            HRESETn,
  oau_serial_mac_if.slave bus
);

  localparam int HALF   = MAX_DIM / 2;
  localparam int PROD_W = IN_WIDTH + 8;
  localparam int ACC_W  = PROD_W + $clog2(HALF);
  localparam int OUT_W  = 2 * IN_WIDTH + 1;
  // One spare bit so adding the rounding constant can never wrap.
  localparam int RND_W  = ACC_W + 1;
  localparam int EXT_W  = (RND_W > OUT_W) ? RND_W : OUT_W;
  localparam logic signed [RND_W-1:0] RND =
    (SHIFT > 0) ? (RND_W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  // Coefficient ROM indexed by {size, k, n}. Entries outside the selected size
  // read as zero, so unused lanes accumulate nothing.
  function automatic logic signed [7:0] coef(input logic sz, input logic [1:0] k,
                                             input logic [1:0] n);
    logic signed [7:0] c;
    c = 8'sd0;
    case ({sz, k, n})
      5'b0_00_00: c = 8'sd83;
      5'b0_00_01: c = 8'sd36;
      5'b0_01_00: c = 8'sd36;
      5'b0_01_01: c = -8'sd83;
      5'b1_00_00: c = 8'sd89;
      5'b1_00_01: c = 8'sd75;
      5'b1_00_10: c = 8'sd50;
      5'b1_00_11: c = 8'sd18;
      5'b1_01_00: c = 8'sd75;
      5'b1_01_01: c = -8'sd18;
      5'b1_01_10: c = -8'sd89;
      5'b1_01_11: c = -8'sd50;
      5'b1_10_00: c = 8'sd50;
      5'b1_10_01: c = -8'sd89;
      5'b1_10_10: c = 8'sd18;
      5'b1_10_11: c = 8'sd75;
      5'b1_11_00: c = 8'sd18;
      5'b1_11_01: c = -8'sd50;
      5'b1_11_10: c = 8'sd75;
      5'b1_11_11: c = -8'sd89;
      default:    c = 8'sd0;
    endcase
    return c;
  endfunction

  logic [1:0]              r_cnt;
  logic                    r_size;
  logic signed [ACC_W-1:0] r_acc      [HALF];
  logic                    r_out_valid;
  logic                    r_out_size;
  logic signed [OUT_W-1:0] r_out_data [HALF];

  logic                    w_size_in;
  logic                    w_size;
  logic                    w_last;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_out_fire;
  logic signed [ACC_W-1:0] w_sum      [HALF];
  logic signed [OUT_W-1:0] w_res      [HALF];

  // A build limited to 4-point can never see an 8-point vector.
  assign w_size_in  = (MAX_DIM == 8) ? bus.size_sel : 1'b0;
  // The size is taken live on the first beat and from the latch afterwards,
  // so mid-vector changes of size_sel have no effect.
  assign w_size     = (r_cnt == 2'd0) ? w_size_in : r_size;
  assign w_last     = (r_cnt == (w_size ? 2'd3 : 2'd1));
  // Only the final beat can stall: it needs the output register to be free
  // (or being freed in this same cycle).
  assign w_in_ready = !bus.clear && !(w_last && r_out_valid && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  for (genvar g = 0; g < HALF; g++) begin : g_lane
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [RND_W-1:0]  w_rnd;
    logic signed [RND_W-1:0]  w_shr;
    logic signed [EXT_W-1:0]  w_ext;

    assign w_prod = PROD_W'(coef(w_size, 2'(g), r_cnt)) * PROD_W'(bus.in_data);
    // The first beat loads instead of adding, so no clear cycle is needed
    // between vectors.
    assign w_base = (r_cnt == 2'd0) ? '0 : r_acc[g];
    assign w_sum[g] = w_base + ACC_W'(w_prod);
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    assign w_rnd = RND_W'(w_sum[g]) + RND;
    assign w_shr = w_rnd >>> SHIFT;
    assign w_ext = EXT_W'(w_shr);
    assign w_res[g] = (g >= 2 && !w_size) ? '0 : w_ext[OUT_W-1:0];

    assign bus.out_data[g] = r_out_data[g];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt       <= 2'd0;
      r_size      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_size  <= 1'b0;
      for (int k = 0; k < HALF; k++) begin
        r_acc[k]      <= '0;
        r_out_data[k] <= '0;
      end
    end else if (bus.clear) begin
      // Output data deliberately keeps its last value.
      r_cnt       <= 2'd0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < HALF; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        for (int k = 0; k < HALF; k++) begin
          r_acc[k] <= w_sum[k];
        end
        if (r_cnt == 2'd0) begin
          r_size <= w_size_in;
        end
        if (w_last) begin
          r_cnt       <= 2'd0;
          r_out_valid <= 1'b1;
          r_out_size  <= w_size;
          for (int k = 0; k < HALF; k++) begin
            r_out_data[k] <= w_res[k];
          end
        end else begin
          r_cnt <= r_cnt + 2'd1;
        end
      end
      // A consumed result is replaced without a bubble when a new last beat
      // lands in the same cycle.
      if (w_out_fire && !(w_accept && w_last)) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_size  = r_out_size;

endmodule

// File: tb/tb_oau_serial_mac.sv
module tb_oau_serial_mac;
  localparam int IN_WIDTH = 16;
  localparam int MAX_DIM  = 8;
  localparam int SH       = 7;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic t_clear = 1'b0;
  logic t_size  = 1'b0;
  logic t_valid = 1'b0;
  logic t_ready = 1'b0;
  logic signed [IN_WIDTH-1:0] t_data = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  oau_serial_mac_if #(.IN_WIDTH(IN_WIDTH), .MAX_DIM(MAX_DIM)) if_a ();
  oau_serial_mac_if #(.IN_WIDTH(IN_WIDTH), .MAX_DIM(MAX_DIM)) if_b ();

  assign if_a.clear     = t_clear;
  assign if_a.size_sel  = t_size;
  assign if_a.in_valid  = t_valid;
  assign if_a.in_data   = t_data;
  assign if_a.out_ready = t_ready;
  assign if_b.clear     = t_clear;
  assign if_b.size_sel  = t_size;
  assign if_b.in_valid  = t_valid;
  assign if_b.in_data   = t_data;
  assign if_b.out_ready = t_ready;

  oau_serial_mac #(.IN_WIDTH(IN_WIDTH), .MAX_DIM(MAX_DIM), .SHIFT(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if_a)
  );
  oau_serial_mac #(.IN_WIDTH(IN_WIDTH), .MAX_DIM(MAX_DIM), .SHIFT(SH)) u_dut7 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if_b)
  );

  // Reference coefficient matrices.
  int C8 [4][4] = '{'{89, 75, 50, 18}, '{75, -18, -89, -50},
                    '{50, -89, 18, 75}, '{18, -50, 75, -89}};
  int C4 [2][2] = '{'{83, 36}, '{36, -83}};

  typedef struct packed {
    logic             sz;
    logic [3:0][32:0] d0;
    logic [3:0][32:0] d7;
  } exp_t;

  longint beats [$];
  logic   cur_sz;
  exp_t   exp_q [$];
  exp_t   last_e;
  bit     last_in_fire;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rounding shift: floor((s + 2^(SH-1)) / 2^SH).
  function automatic longint round_shift(input longint s);
    longint t, d;
    d = longint'(1) << SH;
    t = s + (d / 2);
    if (t >= 0) return t / d;
    return -((-t + d - 1) / d);
  endfunction

  function automatic exp_t make_exp(input logic sz, input longint b [$]);
    exp_t   e;
    longint s, r;
    e = '0;
    e.sz = sz;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      if (sz) begin
        for (int n = 0; n < 4; n++) s += longint'(C8[k][n]) * b[n];
      end else if (k < 2) begin
        for (int n = 0; n < 2; n++) s += longint'(C4[k][n]) * b[n];
      end
      r = round_shift(s);
      e.d0[k] = s[32:0];
      e.d7[k] = r[32:0];
    end
    return e;
  endfunction

  // Observes the cycle just before the rising edge and advances the model.
  task automatic monitor();
    exp_t cur;
    int   nb;
    bit   exp_rdy;
    logic sz;
    last_in_fire = 0;
    if (!HRESETn) begin
      beats.delete();
      exp_q.delete();
      last_e = '0;
      return;
    end
    cur = (exp_q.size() != 0) ? exp_q[0] : last_e;
    chk("out_valid_s0", if_a.out_valid, exp_q.size() != 0);
    chk("out_valid_s7", if_b.out_valid, exp_q.size() != 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_data_s0[%0d]", k), if_a.out_data[k], $signed(cur.d0[k]));
      chk($sformatf("out_data_s7[%0d]", k), if_b.out_data[k], $signed(cur.d7[k]));
    end
    chk("out_size_s0", if_a.out_size, cur.sz);
    chk("out_size_s7", if_b.out_size, cur.sz);
    if (t_clear) begin
      chk("in_ready_clear", if_a.in_ready, 0);
      last_e = cur;
      beats.delete();
      exp_q.delete();
      return;
    end
    sz = (beats.size() == 0) ? t_size : cur_sz;
    nb = sz ? 4 : 2;
    exp_rdy = !(beats.size() == nb - 1 && exp_q.size() != 0 && !t_ready);
    chk("in_ready_s0", if_a.in_ready, exp_rdy);
    chk("in_ready_s7", if_b.in_ready, exp_rdy);
    if (if_a.out_valid && t_ready && exp_q.size() != 0) begin
      last_e = exp_q.pop_front();
    end
    if (t_valid && if_a.in_ready) begin
      last_in_fire = 1;
      if (beats.size() == 0) cur_sz = t_size;
      beats.push_back(longint'(t_data));
      if (beats.size() == (cur_sz ? 4 : 2)) begin
        exp_q.push_back(make_exp(cur_sz, beats));
        beats.delete();
      end
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
    monitor();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send_beat(input longint d, input logic sz);
    bit ok;
    ok = 0;
    t_valid = 1'b1;
    t_data  = IN_WIDTH'(d);
    t_size  = sz;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = last_in_fire;
    end
    t_valid = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic consume();
    t_ready = 1'b1;
    tick();
    t_ready = 1'b0;
    chk("consumed", if_a.out_valid, 0);
  endtask

  initial begin
    last_e = '0;
    cur_sz = 1'b0;
    repeat (2) tick();
    HRESETn = 1'b1;
    #1;
    chk("rst_in_ready", if_a.in_ready, 1);
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_out_size", if_a.out_size, 0);
    for (int k = 0; k < 4; k++) chk("rst_out_data", if_a.out_data[k], 0);
    tick();

    // 8-point 1,2,3,4; later beats toggle size_sel, which must be ignored.
    send_beat(1, 1'b1);
    send_beat(2, 1'b0);
    send_beat(3, 1'b0);
    send_beat(4, 1'b0);
    chk("p8_valid", if_a.out_valid, 1);
    chk("p8_d0", if_a.out_data[0], 461);
    chk("p8_d1", if_a.out_data[1], -428);
    chk("p8_d2", if_a.out_data[2], 226);
    chk("p8_d3", if_a.out_data[3], -213);
    chk("p8_size", if_a.out_size, 1);
    chk("sh7_d0", if_b.out_data[0], 4);
    chk("sh7_d1", if_b.out_data[1], -3);
    chk("sh7_d2", if_b.out_data[2], 2);
    chk("sh7_d3", if_b.out_data[3], -2);
    consume();

    // 4-point 10,-3.
    send_beat(10, 1'b0);
    chk("p4_valid_early", if_a.out_valid, 0);
    send_beat(-3, 1'b1);
    chk("p4_valid", if_a.out_valid, 1);
    chk("p4_d0", if_a.out_data[0], 722);
    chk("p4_d1", if_a.out_data[1], 609);
    chk("p4_d2", if_a.out_data[2], 0);
    chk("p4_d3", if_a.out_data[3], 0);
    chk("p4_size", if_a.out_size, 0);
    consume();

    // Back-to-back vectors with the consumer stalled.
    send_beat(1, 1'b1);
    send_beat(2, 1'b1);
    send_beat(3, 1'b1);
    send_beat(4, 1'b1);
    send_beat(5, 1'b1);
    send_beat(-6, 1'b1);
    send_beat(7, 1'b1);
    t_valid = 1'b1;
    t_data  = -16'sd8;
    #1;
    chk("b2b_stall", if_a.in_ready, 0);
    tick();
    tick();
    chk("b2b_hold_d0", if_a.out_data[0], 461);
    t_ready = 1'b1;
    #1;
    chk("b2b_release", if_a.in_ready, 1);
    tick();
    t_valid = 1'b0;
    t_ready = 1'b0;
    chk("b2b_valid", if_a.out_valid, 1);
    chk("b2b_d0", if_a.out_data[0], 201);
    consume();

    // Extremes.
    for (int i = 0; i < 4; i++) send_beat(-32768, 1'b1);
    chk("ext_d0", if_a.out_data[0], -7602176);
    consume();

    // Clear after two beats, with a beat offered during clear.
    send_beat(9, 1'b1);
    send_beat(9, 1'b1);
    t_clear = 1'b1;
    t_valid = 1'b1;
    t_data  = 16'sd9;
    tick();
    t_clear = 1'b0;
    t_valid = 1'b0;
    chk("clr_hold_d0", if_a.out_data[0], -7602176);
    send_beat(1, 1'b1);
    send_beat(2, 1'b1);
    send_beat(3, 1'b1);
    send_beat(4, 1'b1);
    chk("clr_d0", if_a.out_data[0], 461);
    chk("clr_d3", if_a.out_data[3], -213);

    // Asynchronous reset with a result pending and a vector half collected.
    send_beat(5, 1'b1);
    send_beat(6, 1'b1);
    HRESETn = 1'b0;
    #1;
    chk("arst_valid", if_a.out_valid, 0);
    chk("arst_d0", if_a.out_data[0], 0);
    chk("arst_d1", if_b.out_data[1], 0);
    chk("arst_size", if_a.out_size, 0);
    tick();
    HRESETn = 1'b1;
    tick();
    send_beat(1, 1'b1);
    send_beat(2, 1'b1);
    send_beat(3, 1'b1);
    send_beat(4, 1'b1);
    chk("arst_new_d0", if_a.out_data[0], 461);
    chk("arst_new_d1", if_a.out_data[1], -428);
    consume();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      t_valid = ($urandom_range(0, 3) != 0);
      t_size  = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       t_data = -16'sd32768;
        1:       t_data = 16'sd32767;
        default: t_data = IN_WIDTH'($urandom);
      endcase
      t_ready = ($urandom_range(0, 2) != 0);
      t_clear = ($urandom_range(0, 99) == 0);
      tick();
    end
    t_valid = 1'b0;
    t_clear = 1'b0;
    t_ready = 1'b1;
    repeat (3) tick();
    chk("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/oau_serial_mac.md
# oau_serial_mac

Serial, parametrised successor to the butterfly output add unit in the IntDCT datapath. It takes one odd-part butterfly difference per beat over a valid/ready stream and multiply-accumulates it against the DCT odd-coefficient matrix. It presents a full vector of odd transform outputs with optional rounding shift. Point size (4 or 8) is selectable per vector at runtime, up to the `MAX_DIM` configured at build time.

## Interface
- `IN_WIDTH`, 16: signed width of each input difference.
- `MAX_DIM`, 8: largest transform size supported; legal values are 4 and 8.
- `SHIFT`, 0: rounding right-shift applied to each output; 0 means bypass.
- `HCLK`  in  1: clock; all state is on the rising edge.
- `HRESETn`  in  1: reset, asynchronous and active-low.
- `clear`  in  1: synchronous abort.
- `size_sel`  in  1: transform size; 0 = 4-point, 1 = 8-point. Forced to 0 when `MAX_DIM`=4. Sampled on the first beat of each vector.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: input beat accepted when high together with `in_valid`.
- `in_data`  in  IN_WIDTH: signed odd input n, presented in order n=0,1,….
- `out_valid`  out  1: result vector valid.
- `out_ready`  in  1: result consumed when high together with `out_valid`.
- `out_data[MAX_DIM/2]`  out  2*IN_WIDTH+1 each: signed odd outputs k.
- `out_size`  out  1: the `size_sel` value captured for the vector currently on the output.

## Operation
- Coefficients are 8-bit signed, held in a ROM indexed [k][n].
  - 4-point: rows {83,36} and {36,-83}.
  - 8-point: rows {89,75,50,18}, {75,-18,-89,-50}, {50,-89,18,75}, {18,-50,75,-89}.
- Result definition: out_data[k] = Σn C[k][n]·in[n].
- Beat counter `cnt`:
  - Runs 0..N-1, where N = 2 for a 4-point vector and N = 4 for an 8-point vector.
  - The size is latched on the beat with cnt=0. Changes to `size_sel` mid-vector are ignored.
- Accumulation on each accepted beat:
  - With cnt=0: every acc[k] is loaded with C[k][0]·in_data; no separate clear cycle is needed.
  - Otherwise: acc[k] += C[k][cnt]·in_data, for all k in parallel.
- Accumulator width: IN_WIDTH+8+log2(MAX_DIM/2). Arithmetic never overflows internally.
- Last beat (cnt=N-1):
  - The final sums, with the shift applied, are written into the output register.
  - `out_valid` is set and `cnt` returns to 0.
- Unused outputs: for a 4-point vector, out_data[2..3] are driven to 0.
- Shift: when `SHIFT`>0, out = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. arithmetic shift rounding toward +∞ at the half. The result is sign-extended to 2*IN_WIDTH+1 bits.
- Output register is separate from the accumulators:
  - Input collection for the next vector continues while a result is held.
  - in_ready = !(cnt==N-1 && out_valid && !out_ready). Only the final beat stalls, and only if the previous result has not been consumed.
  - N is taken from the latched size, or from `size_sel` when cnt=0.
- `out_valid` stays high, with data and `out_size` stable, until `out_ready`. It clears on the handshake unless a new last beat is accepted in the same cycle, in which case the new result loads and `out_valid` stays 1.
- `clear`:
  - Sets cnt=0 and out_valid=0 and zeroes the accumulators.
  - Overrides any same-cycle handshake; in_ready=0 during clear.
  - Output data holds its last value.
- Reset values: `in_ready`=1, `out_valid`=0, all `out_data`=0, `out_size`=0, cnt=0, accumulators 0.

## Timing
- Accepts one beat per cycle; throughput is one vector per N cycles.
- Latency: `out_valid` rises on the cycle after the last beat is accepted.
- `in_ready` depends combinationally on `out_ready`. All other outputs are registered.
- `HRESETn` asserted mid-vector: partial sums are discarded and all outputs return to their reset values immediately (asynchronous).

## Test plan
- 8-point, SHIFT=0, beats 1,2,3,4 → one cycle after the 4th beat: out_data = 461, -428, 226, -213; out_size=1.
- 4-point, beats 10,-3 → out_data = 722, 609, 0, 0; out_size=0; `out_valid` two cycles after the first beat.
- SHIFT=7, 8-point beats 1,2,3,4 → out_data = 4, -3, 2, -2.
- Back-to-back 8-point vectors with `out_ready` held 0:
  - `in_ready` drops only at the second vector's 4th beat, and the first result stays stable.
  - Raising `out_ready` accepts the beat and the second result appears with `out_valid` continuously 1.
- Extremes: 8-point, all beats -32768 → out_data[0] = -7602176; the other outputs match the reference model exactly, with no wrap.
- Assert `clear` after 2 beats, then send beats 1,2,3,4 → result equals the clean case. Repeat the same scenario with `HRESETn` pulsed mid-vector: all outputs read 0 until the new result arrives.
